// File: rtl/hwpe_tcdm_arb_package.sv
// Shared constants and types for the HWPE TCDM round-robin arbiter.
// The optional burst lock is enabled with the HWPE_TCDM_ARB_BURST_LOCK_EN macro.
package hwpe_tcdm_arb_package;

   localparam int BURST_MAX       = 4;
   localparam int N_REQ_DEFAULT   = 3;
   localparam int TCDM_ADDR_WIDTH = 32;
   localparam int TCDM_DATA_WIDTH = 32;

   // A single requester still needs a one-bit ID so the FIFO never collapses to zero width
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ARB_ID_WIDTH = id_width(N_REQ_DEFAULT);

   typedef struct packed {
      logic [TCDM_ADDR_WIDTH-1:0]   add;
      logic                         wen;
      logic [TCDM_DATA_WIDTH/8-1:0] be;
      logic [TCDM_DATA_WIDTH-1:0]   data;
   } tcdm_req_t;

endpackage

// File: rtl/hwpe_tcdm_arb_id_fifo.sv
// In-order FIFO of granted requester IDs; synchronous reset, push and pop may
// happen in the same cycle. DEPTH must be a power of two so pointers wrap freely.
module hwpe_tcdm_arb_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset: an entry is only read after it has been written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/hwpe_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM port among N_REQ streamers, routing responses in order.
// Define HWPE_TCDM_ARB_BURST_LOCK_EN to let a requester keep the port for up to BURST_MAX accepts.
module hwpe_tcdm_rr_arbiter
   import hwpe_tcdm_arb_package::*;
#(
   parameter int N_REQ           = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N_REQ-1:0]                       in_req,
   output logic [N_REQ-1:0]                       in_gnt,
   input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]       in_add,
   input  logic [N_REQ-1:0]                       in_wen,
   input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]     in_be,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]       in_data,
   output logic [N_REQ-1:0][DATA_WIDTH-1:0]       in_r_data,
   output logic [N_REQ-1:0]                       in_r_valid,
   output logic                                   tcdm_req,
   input  logic                                   tcdm_gnt,
   output logic [ADDR_WIDTH-1:0]                  tcdm_add,
   output logic                                   tcdm_wen,
   output logic [DATA_WIDTH/8-1:0]                tcdm_be,
   output logic [DATA_WIDTH-1:0]                  tcdm_data,
   input  logic [DATA_WIDTH-1:0]                  tcdm_r_data,
   input  logic                                   tcdm_r_valid,
   output logic                                   busy
);

   localparam int ID_W = id_width(N_REQ);

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] fifo_head;
   logic            found;
   logic            accept;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   int              idx;

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
   endfunction

   // First requester at or after rr_ptr, scanning upward with wrap-around
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % N_REQ;
         if (!found && in_req[idx]) begin
            winner = ID_W'(idx);
            found  = 1'b1;
         end
      end
   end

   assign tcdm_req  = (|in_req) & ~fifo_full;
   assign accept    = tcdm_req & tcdm_gnt;
   assign tcdm_add  = tcdm_req ? in_add[winner]  : '0;
   assign tcdm_wen  = tcdm_req ? in_wen[winner]  : 1'b0;
   assign tcdm_be   = tcdm_req ? in_be[winner]   : '0;
   assign tcdm_data = tcdm_req ? in_data[winner] : '0;
   assign in_gnt    = accept ? (N_REQ'(1) << winner) : '0;

   // A response with nothing in flight is dropped rather than routed to a stale ID
   assign pop        = tcdm_r_valid & ~fifo_empty;
   assign in_r_valid = pop ? (N_REQ'(1) << fifo_head) : '0;
   assign in_r_data  = {N_REQ{tcdm_r_data}};
   assign busy       = ~fifo_empty;

`ifdef HWPE_TCDM_ARB_BURST_LOCK_EN
   logic [1:0]      lock_cnt;
   logic [1:0]      eff_cnt;
   logic [ID_W-1:0] lock_id;

   assign eff_cnt = (winner == lock_id) ? lock_cnt : 2'd0;

   // Pointer parks on the winner until BURST_MAX accepts or the requester lets go
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         lock_cnt <= '0;
         lock_id  <= '0;
      end else if (accept) begin
         lock_id <= winner;
         if (eff_cnt == 2'(BURST_MAX - 1)) begin
            rr_ptr   <= next_id(winner);
            lock_cnt <= '0;
         end else begin
            rr_ptr   <= winner;
            lock_cnt <= eff_cnt + 2'd1;
         end
      end else if (lock_cnt != '0 && !in_req[lock_id]) begin
         rr_ptr   <= next_id(lock_id);
         lock_cnt <= '0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst)         rr_ptr <= '0;
      else if (accept) rr_ptr <= next_id(winner);
   end
`endif

   hwpe_tcdm_arb_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUTSTANDING)
   ) i_id_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (winner),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifndef SYNTHESIS
   assert property (@(posedge clk) disable iff (rst) !(tcdm_r_valid && fifo_empty))
      else $error("tcdm_r_valid received with no transaction in flight");
`endif

endmodule

// File: tb/tb_hwpe_tcdm_rr_arbiter.sv
// Directed bench for hwpe_tcdm_rr_arbiter: arbitration order, response routing,
// full/stall behaviour and reset with transactions in flight.
module tb_hwpe_tcdm_rr_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic                      clk;
   logic                      rst;
   logic [N-1:0]              in_req;
   logic [N-1:0]              in_gnt;
   logic [N-1:0][AW-1:0]      in_add;
   logic [N-1:0]              in_wen;
   logic [N-1:0][DW/8-1:0]    in_be;
   logic [N-1:0][DW-1:0]      in_data;
   logic [N-1:0][DW-1:0]      in_r_data;
   logic [N-1:0]              in_r_valid;
   logic                      tcdm_req;
   logic                      tcdm_gnt;
   logic [AW-1:0]             tcdm_add;
   logic                      tcdm_wen;
   logic [DW/8-1:0]           tcdm_be;
   logic [DW-1:0]             tcdm_data;
   logic [DW-1:0]             tcdm_r_data;
   logic                      tcdm_r_valid;
   logic                      busy;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0]  T1_GNT  [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
   localparam logic [2:0]  T1_RV   [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   localparam logic [31:0] T1_RSP  [7] = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA0, 32'hA1, 32'hA2};
   localparam logic [31:0] T1_ADD  [7] = '{32'h100, 32'h104, 32'h108, 32'h100, 32'h104, 32'h108, 32'h0};
   localparam logic [3:0]  T1_BE   [7] = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h0};
`ifdef HWPE_TCDM_ARB_BURST_LOCK_EN
   localparam logic [2:0]  T6_GNT  [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
`else
   localparam logic [2:0]  T6_GNT  [8] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif

   hwpe_tcdm_rr_arbiter #(
      .N_REQ           (N),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_req       (in_req),
      .in_gnt       (in_gnt),
      .in_add       (in_add),
      .in_wen       (in_wen),
      .in_be        (in_be),
      .in_data      (in_data),
      .in_r_data    (in_r_data),
      .in_r_valid   (in_r_valid),
      .tcdm_req     (tcdm_req),
      .tcdm_gnt     (tcdm_gnt),
      .tcdm_add     (tcdm_add),
      .tcdm_wen     (tcdm_wen),
      .tcdm_be      (tcdm_be),
      .tcdm_data    (tcdm_data),
      .tcdm_r_data  (tcdm_r_data),
      .tcdm_r_valid (tcdm_r_valid),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle's inputs just after the rising edge, then let the combinational paths settle
   task automatic applyStimulus(input logic [N-1:0] req, input logic gnt,
                                input logic rvalid, input logic [DW-1:0] rdata);
      in_req       = req;
      tcdm_gnt     = gnt;
      tcdm_r_valid = rvalid;
      tcdm_r_data  = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
         else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      in_req       = '0;
      tcdm_gnt     = 1'b0;
      tcdm_r_valid = 1'b0;
      tcdm_r_data  = '0;
      for (int i = 0; i < N; i++) begin
         in_add[i]  = 32'h100 + 32'(4 * i);
         in_data[i] = 32'hA0 + 32'(i);
         in_be[i]   = 4'b0001 << i;
         in_wen[i]  = 1'b0;
      end
      tick();
      tick();
      rst = 1'b0;
      applyStimulus('0, 1'b0, 1'b0, '0);
      $display("[TB] reset state");
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_tcdm_req", 64'(tcdm_req), 64'd0);
      checkOutput("rst_in_gnt", 64'(in_gnt), 64'd0);
      checkOutput("rst_in_r_valid", 64'(in_r_valid), 64'd0);
      checkOutput("rst_tcdm_add", 64'(tcdm_add), 64'd0);
      checkOutput("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);

      $display("[TB] all three requesting, response one cycle after grant");
      for (int k = 0; k < 7; k++) begin
         applyStimulus((k < 6) ? 3'b111 : 3'b000, 1'b1, (k > 0), T1_RSP[k]);
         checkOutput($sformatf("rr_gnt_%0d", k), 64'(in_gnt), 64'(T1_GNT[k]));
         checkOutput($sformatf("rr_add_%0d", k), 64'(tcdm_add), 64'(T1_ADD[k]));
         checkOutput($sformatf("rr_be_%0d", k), 64'(tcdm_be), 64'(T1_BE[k]));
         checkOutput($sformatf("rr_rvalid_%0d", k), 64'(in_r_valid), 64'(T1_RV[k]));
         checkOutput($sformatf("rr_rdata_%0d", k), 64'(in_r_data[2]), 64'(T1_RSP[k]));
         tick();
      end
      applyStimulus('0, 1'b0, 1'b0, '0);
      checkOutput("rr_idle_busy", 64'(busy), 64'd0);

      $display("[TB] single requester 2 with pointer at 0");
      applyStimulus(3'b100, 1'b1, 1'b0, '0);
      checkOutput("r2_gnt", 64'(in_gnt), 64'b100);
      checkOutput("r2_data", 64'(tcdm_data), 64'hA2);
      tick();
      applyStimulus('0, 1'b0, 1'b1, 32'hBEEF);
      checkOutput("r2_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      checkOutput("r2_busy", 64'(busy), 64'd1);
      checkOutput("r2_rvalid", 64'(in_r_valid), 64'b100);
      checkOutput("r2_rdata", 64'(in_r_data[0]), 64'hBEEF);
      tick();

      $display("[TB] fill the in-flight FIFO");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(3'b001, 1'b1, 1'b0, '0);
         checkOutput($sformatf("full_gnt_%0d", k), 64'(in_gnt), 64'b001);
         tick();
         checkOutput($sformatf("full_busy_%0d", k), 64'(busy), 64'd1);
      end
      applyStimulus(3'b001, 1'b1, 1'b0, '0);
      checkOutput("full_req_off", 64'(tcdm_req), 64'd0);
      checkOutput("full_gnt_off", 64'(in_gnt), 64'd0);
      applyStimulus(3'b001, 1'b1, 1'b1, 32'h55);
      checkOutput("full_pop_req_off", 64'(tcdm_req), 64'd0);
      checkOutput("full_pop_rvalid", 64'(in_r_valid), 64'b001);
      tick();
      applyStimulus(3'b001, 1'b1, 1'b0, '0);
      checkOutput("full_req_back", 64'(tcdm_req), 64'd1);
      checkOutput("full_gnt_back", 64'(in_gnt), 64'b001);
      checkOutput("full_busy_back", 64'(busy), 64'd1);
      tick();
      for (int k = 0; k < 4; k++) begin
         applyStimulus('0, 1'b0, 1'b1, 32'h60 + 32'(k));
         checkOutput($sformatf("drain_rvalid_%0d", k), 64'(in_r_valid), 64'b001);
         checkOutput($sformatf("drain_busy_%0d", k), 64'(busy), 64'd1);
         tick();
      end
      applyStimulus('0, 1'b0, 1'b0, '0);
      checkOutput("drain_busy_end", 64'(busy), 64'd0);

      $display("[TB] grant withheld for three cycles");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(3'b001, 1'b0, 1'b0, '0);
         checkOutput($sformatf("stall_gnt_%0d", k), 64'(in_gnt), 64'd0);
         checkOutput($sformatf("stall_req_%0d", k), 64'(tcdm_req), 64'd1);
         checkOutput($sformatf("stall_add_%0d", k), 64'(tcdm_add), 64'h100);
         checkOutput($sformatf("stall_ptr_%0d", k), 64'(dut.rr_ptr), 64'd1);
         tick();
      end
      applyStimulus(3'b001, 1'b1, 1'b0, '0);
      checkOutput("stall_gnt_final", 64'(in_gnt), 64'b001);
      tick();
      applyStimulus('0, 1'b0, 1'b1, 32'h11);
      checkOutput("stall_rvalid", 64'(in_r_valid), 64'b001);
      tick();

      $display("[TB] reset with two transactions in flight");
      applyStimulus(3'b011, 1'b1, 1'b0, '0);
      checkOutput("mid_gnt_a", 64'(in_gnt), 64'b010);
      tick();
      applyStimulus(3'b011, 1'b1, 1'b0, '0);
      checkOutput("mid_gnt_b", 64'(in_gnt), 64'b001);
      tick();
      checkOutput("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      applyStimulus('0, 1'b0, 1'b0, '0);
      tick();
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_ptr", 64'(dut.rr_ptr), 64'd0);
      applyStimulus('0, 1'b0, 1'b1, 32'h77);
      checkOutput("mid_stray_rvalid", 64'(in_r_valid), 64'd0);
      tick();
      rst = 1'b0;
      applyStimulus('0, 1'b0, 1'b0, '0);
      checkOutput("mid_after_busy", 64'(busy), 64'd0);
      checkOutput("mid_after_req", 64'(tcdm_req), 64'd0);

      $display("[TB] requesters 0 and 1 held");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(3'b011, 1'b1, (k > 0), 32'hC0 + 32'(k));
         checkOutput($sformatf("pair_gnt_%0d", k), 64'(in_gnt), 64'(T6_GNT[k]));
         if (k > 0)
            checkOutput($sformatf("pair_rvalid_%0d", k), 64'(in_r_valid), 64'(T6_GNT[k - 1]));
         tick();
      end
      applyStimulus('0, 1'b0, 1'b1, 32'hC8);
      checkOutput("pair_rvalid_last", 64'(in_r_valid), 64'(T6_GNT[7]));
      tick();
      applyStimulus('0, 1'b0, 1'b0, '0);
      checkOutput("pair_busy_end", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
